// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory data port: IDLE -> ACCESS -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                gid_q, gid_d;
  logic                we_q, we_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                win;

`ifdef ARB_ROUND_ROBIN_EN
  // Resets to 1 so requester 0 wins the first tie.
  logic last_q, last_d;

  assign win = (req_valid == 2'b11) ? ~last_q : req_valid[1];

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && |req_valid) last_d = win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign win = ~req_valid[0];
`endif

  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_we_d  = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = win ? 2'b10 : 2'b01;
          gid_d     = win;
          we_d      = req_we[win];
          mem_we_d  = req_we[win];
          addr_d    = win ? req_addr1  : req_addr0;
          wdata_d   = win ? req_wdata1 : req_wdata0;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        // Read data returns one cycle after the address was presented in ACCESS.
        rsp_valid = gid_q ? 2'b10 : 2'b01;
        rsp_rdata = we_q ? '0 : mem_rdata;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gid_q    <= 1'b0;
      we_q     <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      we_q     <= we_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of arbitration, timing and memory contents.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [AW-1:0] req_addr0, req_addr1, mem_addr;
  logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, mem_wdata, mem_rdata;
  logic          mem_we, busy, grant_id;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, a};
  endfunction

  // Synchronous-read memory; preloaded on the first clock edge.
  logic [DW-1:0] pmem [0:65535];
  logic          pm_init = 1'b0;
  always @(posedge clk) begin
    if (!pm_init) begin
      for (int a = 0; a < 65536; a++) pmem[a] <= init_val(a[15:0]);
      pm_init <= 1'b1;
    end else begin
      if (mem_we) pmem[mem_addr] <= mem_wdata;
      mem_rdata <= pmem[mem_addr];
    end
  end

  typedef struct {
    int            id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            acc_cyc;
    int            rsp_cyc;
  } txn_t;

  txn_t          exp_q[$];
  int            grant_log[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            checks = 0, failures = 0;
  int            cyc = 0, free_cyc = 0, m_last = 1, m_gid = 0;
  logic [1:0]    hs_s = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ARB_ROUND_ROBIN_EN
    return 1 - last;
`else
    return (last < 0) ? 1 : 0;
`endif
  endfunction

  // Model: accepts a transaction when idle, occupies the port for 3 cycles.
  int         pw, pid;
  logic [1:0] per;
  txn_t       pt;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      free_cyc = cyc; m_last = 1; m_gid = 0; hs_s = 2'b00;
    end else begin
      pw  = pick(req_valid, m_last);
      per = (cyc >= free_cyc && req_valid != 2'b00) ? ((pw == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 64'(req_ready), 64'(per));
      chk("busy", 64'(busy), 64'(cyc < free_cyc));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      hs_s = req_valid & req_ready;
      if (hs_s != 2'b00) begin
        pid        = (hs_s == 2'b10) ? 1 : 0;
        pt.id      = pid;
        pt.we      = req_we[pid];
        pt.addr    = (pid == 1) ? req_addr1 : req_addr0;
        pt.wdata   = (pid == 1) ? req_wdata1 : req_wdata0;
        pt.rdata   = pt.we ? '0 : (ref_mem.exists(pt.addr) ? ref_mem[pt.addr] : init_val(pt.addr));
        pt.acc_cyc = cyc + 1;
        pt.rsp_cyc = cyc + 2;
        exp_q.push_back(pt);
        grant_log.push_back(pid);
        free_cyc = cyc + 3; m_last = pid; m_gid = pid;
      end
    end
  end

  // Monitor: memory-side and response-side checks against the queued expectations.
  txn_t mt;
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].acc_cyc == cyc) begin
        chk("mem_we", 64'(mem_we), 64'(exp_q[0].we));
        chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
        if (exp_q[0].we) begin
          chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
          ref_mem[exp_q[0].addr] = exp_q[0].wdata;
        end
      end else begin
        chk("mem_we_idle", 64'(mem_we), 64'(0));
      end
      if (rsp_valid != 2'b00 || (exp_q.size() > 0 && exp_q[0].rsp_cyc == cyc)) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          mt = exp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(mt.rsp_cyc));
          chk("rsp_valid", 64'(rsp_valid), 64'((mt.id == 1) ? 2'b10 : 2'b01));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(mt.rdata));
        end
      end
    end
  end

  task automatic set_req(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[id] = we;
    if (id == 1) begin req_addr1 = a; req_wdata1 = d; end
    else         begin req_addr0 = a; req_wdata0 = d; end
  endtask

  // Waits for any handshake (bounded), returns at posedge+1 after it.
  task automatic wait_any(output logic [1:0] g, output int hc);
    int n;
    g = 2'b00; hc = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) begin
        g = req_valid & req_ready; hc = cyc;
        break;
      end
    end
    if (n == 40) begin
      checks++; failures++;
      $display("FAIL handshake_timeout: got none expected handshake (cycle %0d)", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [1:0] g; int hc;
    set_req(id, we, a, d);
    req_valid[id] = 1'b1;
    wait_any(g, hc);
    req_valid[id] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [1:0] g;
  int         hc, prev_hc;
  int         exp_order[4];

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_mem_we", 64'(mem_we), 64'(0));
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));
    chk("reset_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_grant_id", 64'(grant_id), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 1'b0, 16'h0010, 32'h0);
    repeat (3) @(posedge clk); #1;

    issue(1, 1'b1, 16'h0020, 32'h12345678);
    issue(1, 1'b0, 16'h0020, 32'h0);
    repeat (3) @(posedge clk); #1;

    // Continuous tie for four grants.
    do_reset();
    grant_log.delete();
    set_req(0, 1'b0, 16'h0003, 32'h0);
    set_req(1, 1'b1, 16'h0004, 32'hCAFE0001);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_any(g, hc);
      if (g[0]) set_req(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
      if (g[1]) set_req(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
    end
    req_valid = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    chk("tie_grant_count", 64'(grant_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk($sformatf("tie_grant_order_%0d", k), 64'(grant_log[k]), 64'(exp_order[k]));
    repeat (3) @(posedge clk); #1;

    // Reset during the ACCESS cycle of a write.
    set_req(0, 1'b1, 16'h0030, 32'hBADC0FFE);
    req_valid[0] = 1'b1;
    wait_any(g, hc);
    chk("abort_mem_we_access", 64'(mem_we), 64'(1));
    #1 rst_n = 1'b0; req_valid = 2'b00;
    #1;
    chk("abort_mem_we", 64'(mem_we), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_grant_id", 64'(grant_id), 64'(0));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    grant_log.delete();
    set_req(0, 1'b0, 16'h0030, 32'h0);
    set_req(1, 1'b0, 16'h0031, 32'h0);
    req_valid = 2'b11;
    wait_any(g, hc);
    req_valid = 2'b00;
    chk("post_reset_tie_winner", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'(0));
    repeat (3) @(posedge clk); #1;

    // Request pulsed during ACCESS must not create a second transaction.
    grant_log.delete();
    set_req(0, 1'b0, 16'h0005, 32'h0);
    req_valid[0] = 1'b1;
    wait_any(g, hc);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("pulse_txn_count", 64'(grant_log.size()), 64'(1));

    // Back-to-back reads from requester 0.
    prev_hc = 0;
    set_req(0, 1'b0, 16'h0010, 32'h0);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_any(g, hc);
      if (k > 0) chk($sformatf("b2b_gap_%0d", k), 64'(hc - prev_hc), 64'(3));
      prev_hc = hc;
      set_req(0, 1'b0, AW'($urandom_range(0, 31)), 32'h0);
    end
    req_valid = 2'b00;
    repeat (3) @(posedge clk);

    // Random traffic: requesters hold until accepted, occasionally withdraw.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && !hs_s[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
          req_valid[i] = 1'b1;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = 2'b00;
    repeat (6) @(posedge clk); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
